// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: tracks each fetched instruction's predicted next PC,
// checks it against the EX outcome, redirects/flushes on mispredict and trains the predictor.
`ifndef DataBusBits
`define DataBusBits 64
`endif

module branch_resolution_unit #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fetch_valid,
    input  logic [`DataBusBits-1:0] fetch_pc,
    input  logic [`DataBusBits-1:0] fetch_pred,
    output logic                    fetch_stall,
    input  logic                    res_valid,
    input  logic                    res_is_cti,
    input  logic                    res_taken,
    input  logic [`DataBusBits-1:0] res_target,
    output logic                    redirect_valid,
    output logic [`DataBusBits-1:0] redirect_pc,
    output logic                    flush,
    output logic                    bp_we,
    output logic                    bp_taken,
    output logic [`DataBusBits-1:0] bp_pc,
    output logic [`DataBusBits-1:0] bp_target,
    output logic [CNT_W-1:0]        cti_count,
    output logic [CNT_W-1:0]        mispred_count,
    output logic                    underflow_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CQ_W  = PTR_W + 1;
    localparam int REC_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {NORMAL, RECOVER} state_t;

    state_t                  state;
    logic [REC_W-1:0]        recCnt;
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [CQ_W-1:0]         count;
    logic [`DataBusBits-1:0] pcQ   [DEPTH];
    logic [`DataBusBits-1:0] predQ [DEPTH];

    logic                    full;
    logic                    resolveOk;
    logic                    mispredict;
    logic                    pushOk;
    logic [`DataBusBits-1:0] headPc;
    logic [`DataBusBits-1:0] actualNext;

    // A full queue still accepts a push when the head pops in the same cycle.
    always_comb begin
        full        = (count == CQ_W'(DEPTH));
        fetch_stall = full | (state == RECOVER);
        flush       = (state == RECOVER);
        headPc      = pcQ[head];
        resolveOk   = res_valid & (count != '0) & (state == NORMAL);
        actualNext  = (res_is_cti & res_taken) ? res_target
                                               : headPc + `DataBusBits'(4);
        mispredict  = resolveOk & (actualNext != predQ[head]);
        pushOk      = fetch_valid & (state == NORMAL) & ~mispredict & (~full | resolveOk);
    end

    always_ff @(posedge clk) begin
        if (pushOk) begin
            pcQ[tail]   <= fetch_pc;
            predQ[tail] <= fetch_pred;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= NORMAL;
            recCnt         <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            bp_we          <= 1'b0;
            bp_taken       <= 1'b0;
            bp_pc          <= '0;
            bp_target      <= '0;
            cti_count      <= '0;
            mispred_count  <= '0;
            underflow_err  <= 1'b0;
        end else begin
            redirect_valid <= 1'b0;
            bp_we          <= 1'b0;

            case (state)
                NORMAL: begin
                    if (mispredict) begin
                        state          <= RECOVER;
                        recCnt         <= REC_W'(FLUSH_CYCLES - 1);
                        head           <= '0;
                        tail           <= '0;
                        count          <= '0;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= actualNext;
                    end else begin
                        if (resolveOk) head <= head + PTR_W'(1);
                        if (pushOk)    tail <= tail + PTR_W'(1);
                        if (pushOk && !resolveOk)      count <= count + CQ_W'(1);
                        else if (!pushOk && resolveOk) count <= count - CQ_W'(1);
                    end
                    if (res_valid && count == '0) underflow_err <= 1'b1;
                end
                RECOVER: begin
                    if (recCnt == '0) state  <= NORMAL;
                    else              recCnt <= recCnt - REC_W'(1);
                end
                default: state <= NORMAL;
            endcase

            // Training and statistics only see resolves accepted in NORMAL.
            if (resolveOk && res_is_cti) begin
                bp_we     <= 1'b1;
                bp_pc     <= headPc;
                bp_target <= res_target;
                bp_taken  <= res_taken;
                if (cti_count != '1) cti_count <= cti_count + CNT_W'(1);
            end
            if (mispredict && mispred_count != '1)
                mispred_count <= mispred_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Bench for branch_resolution_unit: directed scenarios then random traffic,
// all checked against a queue-based reference model of the resolution rules.
`ifndef DataBusBits
`define DataBusBits 64
`endif

module tb_branch_resolution_unit;

    localparam int DEPTH        = 4;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 4;
    localparam int W            = `DataBusBits;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             fetch_valid;
    logic [W-1:0]     fetch_pc;
    logic [W-1:0]     fetch_pred;
    logic             fetch_stall;
    logic             res_valid;
    logic             res_is_cti;
    logic             res_taken;
    logic [W-1:0]     res_target;
    logic             redirect_valid;
    logic [W-1:0]     redirect_pc;
    logic             flush;
    logic             bp_we;
    logic             bp_taken;
    logic [W-1:0]     bp_pc;
    logic [W-1:0]     bp_target;
    logic [CNT_W-1:0] cti_count;
    logic [CNT_W-1:0] mispred_count;
    logic             underflow_err;

    branch_resolution_unit #(
        .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_pred(fetch_pred),
        .fetch_stall(fetch_stall),
        .res_valid(res_valid), .res_is_cti(res_is_cti), .res_taken(res_taken),
        .res_target(res_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .bp_we(bp_we), .bp_taken(bp_taken), .bp_pc(bp_pc), .bp_target(bp_target),
        .cti_count(cti_count), .mispred_count(mispred_count),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: in-flight predictions as plain queues, RECOVER as cycles left.
    logic [W-1:0] qPc[$];
    logic [W-1:0] qPred[$];
    int           recLeft;
    logic         expRv, expBpWe, expBpTk, expUf;
    logic [W-1:0] expRpc, expBpPc, expBpTgt;
    int           expCti, expMis;

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic modelReset();
        qPc.delete();
        qPred.delete();
        recLeft = 0;
        expRv = 0; expBpWe = 0; expBpTk = 0; expUf = 0;
        expRpc = '0; expBpPc = '0; expBpTgt = '0;
        expCti = 0; expMis = 0;
    endtask

    task automatic modelStep();
        logic [W-1:0] hPc, hPred, act;
        bit mis = 0;
        bit pop = 0;
        int sz  = qPc.size();
        expRv   = 0;
        expBpWe = 0;
        if (recLeft > 0) begin
            recLeft--;
        end else begin
            if (res_valid && sz == 0) expUf = 1;
            if (res_valid && sz > 0) begin
                pop   = 1;
                hPc   = qPc.pop_front();
                hPred = qPred.pop_front();
                act   = (res_is_cti && res_taken) ? res_target : hPc + 4;
                mis   = (act != hPred);
                if (res_is_cti) begin
                    expBpWe = 1; expBpPc = hPc; expBpTgt = res_target; expBpTk = res_taken;
                    expCti  = sat(expCti);
                end
                if (mis) begin
                    expMis = sat(expMis);
                    expRv  = 1;
                    expRpc = act;
                    qPc.delete();
                    qPred.delete();
                    recLeft = FLUSH_CYCLES;
                end
            end
            if (fetch_valid && !mis && (sz < DEPTH || pop)) begin
                qPc.push_back(fetch_pc);
                qPred.push_back(fetch_pred);
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput("redirect_valid", 64'(redirect_valid), 64'(expRv));
        checkOutput("redirect_pc", redirect_pc, expRpc);
        checkOutput("flush", 64'(flush), 64'(recLeft > 0));
        checkOutput("fetch_stall", 64'(fetch_stall), 64'(qPc.size() == DEPTH || recLeft > 0));
        checkOutput("bp_we", 64'(bp_we), 64'(expBpWe));
        checkOutput("bp_pc", bp_pc, expBpPc);
        checkOutput("bp_target", bp_target, expBpTgt);
        checkOutput("bp_taken", 64'(bp_taken), 64'(expBpTk));
        checkOutput("cti_count", 64'(cti_count), 64'(expCti));
        checkOutput("mispred_count", 64'(mispred_count), 64'(expMis));
        checkOutput("underflow_err", 64'(underflow_err), 64'(expUf));
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic fv, input logic [W-1:0] fpc, input logic [W-1:0] fpred,
                                 input logic rv, input logic cti, input logic tk,
                                 input logic [W-1:0] tgt);
        fetch_valid = fv; fetch_pc = fpc; fetch_pred = fpred;
        res_valid = rv; res_is_cti = cti; res_taken = tk; res_target = tgt;
        @(posedge clk);
        #1;
        modelStep();
        checkAll();
    endtask

    task automatic pushOnly(input logic [W-1:0] pc, input logic [W-1:0] pred);
        applyStimulus(1, pc, pred, 0, 0, 0, '0);
    endtask

    task automatic idle();
        applyStimulus(0, '0, '0, 0, 0, 0, '0);
    endtask

    // Asynchronous reset between clock edges; checked before any edge arrives.
    task automatic doReset();
        fetch_valid = 0; res_valid = 0; res_is_cti = 0; res_taken = 0;
        #2 reset = 0;
        #1;
        modelReset();
        checkAll();
        #2 reset = 1;
    endtask

    initial begin
        logic [W-1:0] pc, pred, tgt;
        reset = 0;
        fetch_valid = 0; fetch_pc = '0; fetch_pred = '0;
        res_valid = 0; res_is_cti = 0; res_taken = 0; res_target = '0;
        @(posedge clk);
        #1;
        doReset();

        // Correctly predicted non-CTI.
        pushOnly(64'h100, 64'h104);
        applyStimulus(0, '0, '0, 1, 0, 0, '0);
        checkOutput("s1_redirect", 64'(redirect_valid), 64'd0);
        checkOutput("s1_bp_we", 64'(bp_we), 64'd0);
        checkOutput("s1_cti_count", 64'(cti_count), 64'd0);

        // Taken branch mispredicted as fall-through.
        doReset();
        pushOnly(64'h200, 64'h204);
        applyStimulus(0, '0, '0, 1, 1, 1, 64'h300);
        checkOutput("s2_redirect_valid", 64'(redirect_valid), 64'd1);
        checkOutput("s2_redirect_pc", redirect_pc, 64'h300);
        checkOutput("s2_bp_pc", bp_pc, 64'h200);
        checkOutput("s2_bp_target", bp_target, 64'h300);
        checkOutput("s2_mispred", 64'(mispred_count), 64'd1);
        idle();
        checkOutput("s2_pulse_once", 64'(redirect_valid), 64'd0);
        checkOutput("s2_flush_c2", 64'(flush), 64'd1);
        idle();
        checkOutput("s2_flush_end", 64'(flush), 64'd0);

        // Taken branch correctly predicted.
        doReset();
        pushOnly(64'h400, 64'h480);
        applyStimulus(0, '0, '0, 1, 1, 1, 64'h480);
        checkOutput("s3_bp_we", 64'(bp_we), 64'd1);
        checkOutput("s3_cti", 64'(cti_count), 64'd1);
        checkOutput("s3_mispred", 64'(mispred_count), 64'd0);

        // PC wraps modulo 2^64 on fall-through.
        pushOnly(64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
        applyStimulus(0, '0, '0, 1, 0, 0, '0);
        checkOutput("wrap_no_redirect", 64'(redirect_valid), 64'd0);

        // Fill, drop on full, push+pop while full, FIFO drain.
        doReset();
        for (int i = 0; i < DEPTH; i++) pushOnly(64'h500 + 64'(i * 16), 64'h504 + 64'(i * 16));
        checkOutput("s4_full_stall", 64'(fetch_stall), 64'd1);
        pushOnly(64'h540, 64'h544);
        applyStimulus(1, 64'h550, 64'h554, 1, 1, 0, 64'h999);
        checkOutput("s4_still_full", 64'(fetch_stall), 64'd1);
        checkOutput("s4_pop0", bp_pc, 64'h500);
        applyStimulus(0, '0, '0, 1, 1, 0, 64'h999);
        checkOutput("s4_pop1", bp_pc, 64'h510);
        applyStimulus(0, '0, '0, 1, 1, 0, 64'h999);
        checkOutput("s4_pop2", bp_pc, 64'h520);
        applyStimulus(0, '0, '0, 1, 1, 0, 64'h999);
        checkOutput("s4_pop3", bp_pc, 64'h530);
        applyStimulus(0, '0, '0, 1, 1, 0, 64'h999);
        checkOutput("s4_pop4", bp_pc, 64'h550);
        checkOutput("s4_empty", 64'(fetch_stall), 64'd0);

        // Underflow is sticky; pushes during RECOVER are dropped.
        doReset();
        applyStimulus(0, '0, '0, 1, 1, 1, 64'h10);
        checkOutput("s5_underflow", 64'(underflow_err), 64'd1);
        checkOutput("s5_no_train", 64'(bp_we), 64'd0);
        idle();
        idle();
        checkOutput("s5_sticky", 64'(underflow_err), 64'd1);
        pushOnly(64'h600, 64'h700);
        applyStimulus(1, 64'h620, 64'h624, 1, 0, 0, '0);
        checkOutput("s5_redirect_pc", redirect_pc, 64'h604);
        applyStimulus(1, 64'h700, 64'h704, 1, 1, 1, 64'h40);
        applyStimulus(1, 64'h710, 64'h714, 0, 0, 0, '0);
        applyStimulus(0, '0, '0, 1, 1, 1, 64'h800);
        checkOutput("s5_recover_push_dropped", 64'(bp_we), 64'd0);
        checkOutput("s5_cti", 64'(cti_count), 64'd0);

        // Reset with entries queued, then reset in the middle of RECOVER.
        doReset();
        for (int i = 0; i < 3; i++) pushOnly(64'h900 + 64'(i * 4), 64'h904 + 64'(i * 4));
        doReset();
        applyStimulus(0, '0, '0, 1, 1, 0, '0);
        checkOutput("s6_queue_cleared", 64'(underflow_err), 64'd1);
        for (int i = 0; i < 3; i++) pushOnly(64'hA00 + 64'(i * 4), 64'hA04 + 64'(i * 4));
        applyStimulus(0, '0, '0, 1, 1, 1, 64'hB00);
        checkOutput("s6_in_recover", 64'(flush), 64'd1);
        doReset();
        checkOutput("s6_flush_async", 64'(flush), 64'd0);
        checkOutput("s6_stall_async", 64'(fetch_stall), 64'd0);
        checkOutput("s6_mispred_async", 64'(mispred_count), 64'd0);

        // Random traffic; counters are narrow so saturation is exercised.
        for (int n = 0; n < 600; n++) begin
            pc   = 64'h1000 + 64'($urandom_range(0, 1023)) * 4;
            pred = ($urandom_range(0, 1) == 1) ? pc + 4 : pc + 64'h40;
            if (qPc.size() > 0 && $urandom_range(0, 9) < 7) tgt = qPred[0];
            else tgt = 64'h1000 + 64'($urandom_range(0, 1023)) * 4;
            applyStimulus($urandom_range(0, 99) < 60, pc, pred,
                          $urandom_range(0, 99) < 50, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1, tgt);
        end
        checkOutput("rand_mispred_saturated", 64'(mispred_count), 64'(CNT_MAX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolution_unit.md
Name: branch_resolution_unit

Overview:
- Update-side counterpart of the bimodal predictor: tracks every fetched instruction's predicted next PC in an in-order queue.
- Compares each prediction against the outcome resolved in EX; on mismatch, issues a redirect and flush.
- Drives the predictor's training port (we, PCUpdate, targetUpdate, takenUpdate).
- Sits between fetch (push side) and the execute stage (resolve side).

Parameters:
- DEPTH, 4, in-flight prediction queue entries; power of 2, ≥2.
- FLUSH_CYCLES, 2, cycles held in RECOVER after a redirect; ≥1.
- CNT_W, 32, width of saturating statistics counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- fetch_valid  in  1  fetch pushes {fetch_pc, fetch_pred} this cycle.
- fetch_pc  in  `DataBusBits  PC of fetched instruction.
- fetch_pred  in  `DataBusBits  predicted next PC (PCPrediction).
- fetch_stall  out  1  queue full or in RECOVER; fetch must not push.
- res_valid  in  1  EX resolves oldest in-flight instruction this cycle.
- res_is_cti  in  1  instruction is jal/jalr/branch.
- res_taken  in  1  actual direction (1 for jal/jalr).
- res_target  in  `DataBusBits  actual taken target.
- redirect_valid  out  1  one-cycle pulse: mispredict detected.
- redirect_pc  out  `DataBusBits  correct next PC; held until next redirect.
- flush  out  1  high throughout RECOVER; younger stages squash.
- bp_we, bp_taken  out  1 each  predictor training strobe / direction.
- bp_pc, bp_target  out  `DataBusBits  PCUpdate / targetUpdate.
- cti_count, mispred_count  out  CNT_W  statistics.
- underflow_err  out  1  sticky: resolve with empty queue.

Behaviour:
- Reset (async, reset==0): queue empty (head=tail=0, count=0), state NORMAL. All outputs 0, including redirect_pc and counters.
- Queue:
  - Circular, DEPTH entries, pointers wrap modulo DEPTH.
  - count is 0..DEPTH.
  - fetch_stall = (count==DEPTH) | (state==RECOVER), combinational.
  - A push while fetch_stall is ignored.
  - Simultaneous push and pop while full is legal; count stays DEPTH.
- Resolve (res_valid=1, count>0, state NORMAL):
  - Pop head.
  - actual_next = (res_is_cti & res_taken) ? res_target : head_pc+4 (modulo 2^64).
  - mispredict = (actual_next != head_pred).
- Training (registered, 1-cycle latency): when res_is_cti, the next cycle has bp_we=1, bp_pc=head_pc, bp_target=res_target, bp_taken=res_taken. Otherwise bp_we=0. bp_* hold their values when bp_we=0.
- Mispredict handling (registered):
  - Next cycle: redirect_valid=1 for exactly one cycle, redirect_pc=actual_next.
  - Queue cleared, state goes to RECOVER with flush=1 for FLUSH_CYCLES cycles, then back to NORMAL.
  - A push in the same cycle as a mispredicting resolve is discarded.
- In RECOVER, res_valid is ignored: no pop, no training, no counting.
- Empty-queue resolve: underflow_err set and held until reset. No other effect.
- Counters:
  - cti_count increments on each accepted resolve with res_is_cti.
  - mispred_count increments on each mispredict, CTI or not.
  - Both saturate at 2^CNT_W-1.
- Reset asserted mid-RECOVER or with a non-empty queue returns immediately to the reset state.

Test Plan:
- Push pc=0x100 pred=0x104, resolve non-CTI → no redirect, bp_we=0, count back to 0, cti_count=0.
- Push pc=0x200 pred=0x204, resolve taken branch target=0x300 → next cycle redirect_valid=1 (1 cycle), redirect_pc=0x300, bp_we=1, bp_pc=0x200, bp_target=0x300, bp_taken=1, flush high 2 cycles, mispred_count=1.
- Push pc=0x400 pred=0x480, resolve taken branch target=0x480 → no redirect, bp_we=1, bp_taken=1, cti_count=1, mispred_count=0.
- Push 4 entries → fetch_stall=1, 5th push dropped; simultaneous push and resolve → count stays 4; 4 resolves drain in FIFO order.
- res_valid with empty queue → underflow_err=1 and sticky; a push during RECOVER has no effect and count stays 0.
- Assert reset during RECOVER with 3 queued → flush=0, fetch_stall=0, all counters 0 immediately, without waiting for a clock edge.
